// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and FSM encoding for the TDM 1:4 demux
package tdm_pkg;
  localparam int NUM_SLOTS     = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
endpackage

// File: rtl/tdm_bit_shifter.sv
// rtl/tdm_bit_shifter.sv - MSB-first slot deserializer with bit counter
module tdm_bit_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             load_first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next,
  output logic             at_last_bit,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);

  // Only WIDTH-1 bits are stored: the final bit completes the word combinationally.
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    bit_cnt;

  assign word_next   = {shreg, bit_in};
  assign at_last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign word_done   = shift_en && at_last_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load_first) begin
      shreg    <= '0;
      shreg[0] <= bit_in;
      bit_cnt  <= CW'(1);
    end else if (shift_en) begin
      shreg   <= word_next[WIDTH-2:0];
      bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/tdm_demux_1_4.sv
// rtl/tdm_demux_1_4.sv - TDM 1:4 receive demux; TDM_DEMUX_PARITY_EN adds a trailing even-parity bit
module tdm_demux_1_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Data_in,
  input  logic             Data_en,
  input  logic             Data_sync,
  output logic [WIDTH-1:0] Data_o0,
  output logic [WIDTH-1:0] Data_o1,
  output logic [WIDTH-1:0] Data_o2,
  output logic [WIDTH-1:0] Data_o3,
  output logic             Data_frame_done,
  output logic             Data_sync_err,
  output logic             Data_parity_err,
  output logic             Data_busy
);
  localparam logic [1:0] LAST_SLOT = 2'(NUM_SLOTS - 1);

  state_t           state, state_d;
  logic [1:0]       slot;
  logic [WIDTH-1:0] staging [NUM_SLOTS];
  logic             shift_en, load_first, at_last_bit, word_done;
  logic [WIDTH-1:0] word_next, out_w3;
  logic             commit, sync_err_c;

  tdm_bit_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .shift_en    (shift_en),
    .load_first  (load_first),
    .bit_in      (Data_in),
    .word_next   (word_next),
    .at_last_bit (at_last_bit),
    .word_done   (word_done)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic par_acc, parity_err_c;

  assign out_w3 = staging[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc         <= 1'b0;
      Data_parity_err <= 1'b0;
    end else begin
      Data_parity_err <= parity_err_c;
      if (load_first)
        par_acc <= Data_in;
      else if (shift_en)
        par_acc <= par_acc ^ Data_in;
    end
  end
`else
  // Commit happens on the same edge that completes slot 3, so take it straight from the shifter.
  assign out_w3          = word_next;
  assign Data_parity_err = 1'b0;
`endif

  assign Data_busy = (state != HUNT);

  always_comb begin
    state_d    = state;
    shift_en   = 1'b0;
    load_first = 1'b0;
    commit     = 1'b0;
    sync_err_c = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_c = 1'b0;
`endif
    case (state)
      HUNT: begin
        if (Data_en && Data_sync) begin
          load_first = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (Data_en) begin
          if (Data_sync) begin
            load_first = 1'b1;
            sync_err_c = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (at_last_bit && slot == LAST_SLOT) begin
`ifdef TDM_DEMUX_PARITY_EN
              state_d = PARITY;
`else
              commit  = 1'b1;
              state_d = HUNT;
`endif
            end
          end
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      PARITY: begin
        if (Data_en) begin
          if (Data_sync) begin
            load_first = 1'b1;
            sync_err_c = 1'b1;
            state_d    = SHIFT;
          end else begin
            state_d = HUNT;
            if (Data_in == par_acc)
              commit = 1'b1;
            else
              parity_err_c = 1'b1;
          end
        end
      end
`endif
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HUNT;
      slot            <= '0;
      Data_o0         <= '0;
      Data_o1         <= '0;
      Data_o2         <= '0;
      Data_o3         <= '0;
      Data_frame_done <= 1'b0;
      Data_sync_err   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++)
        staging[i] <= '0;
    end else begin
      state           <= state_d;
      Data_frame_done <= commit;
      Data_sync_err   <= sync_err_c;
      if (load_first) begin
        slot <= '0;
        for (int i = 0; i < NUM_SLOTS; i++)
          staging[i] <= '0;
      end else if (word_done) begin
        staging[slot] <= word_next;
        slot          <= slot + 2'd1;
      end
      if (commit) begin
        Data_o0 <= staging[0];
        Data_o1 <= staging[1];
        Data_o2 <= staging[2];
        Data_o3 <= out_w3;
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// tb/tb_tdm_demux_1_4.sv - scoreboard bench for tdm_demux_1_4; honours TDM_DEMUX_PARITY_EN
module tb_tdm_demux_1_4;
  localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FB       = 4 * W + 1;
  localparam int DONE_EXP = 7;
  localparam int PERR_EXP = 1;
`else
  localparam int FB       = 4 * W;
  localparam int DONE_EXP = 6;
  localparam int PERR_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Data_in = 1'b0;
  logic         Data_en = 1'b0;
  logic         Data_sync = 1'b0;
  logic [W-1:0] Data_o0, Data_o1, Data_o2, Data_o3;
  logic         Data_frame_done, Data_sync_err, Data_parity_err, Data_busy;

  tdm_demux_1_4 #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .Data_in         (Data_in),
    .Data_en         (Data_en),
    .Data_sync       (Data_sync),
    .Data_o0         (Data_o0),
    .Data_o1         (Data_o1),
    .Data_o2         (Data_o2),
    .Data_o3         (Data_o3),
    .Data_frame_done (Data_frame_done),
    .Data_sync_err   (Data_sync_err),
    .Data_parity_err (Data_parity_err),
    .Data_busy       (Data_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int serr_cnt = 0;
  int perr_cnt = 0;
  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] cur = '0;
  bit busy_drop;
  int t0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cur = '0;
    end else begin
      if (Data_frame_done) begin
        done_cnt++;
        chk("done_exclusive", {Data_sync_err, Data_parity_err}, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("frame_out", {Data_o0, Data_o1, Data_o2, Data_o3}, cur);
        end
      end
      if (Data_sync_err) begin
        serr_cnt++;
        chk("sync_err_hold", {Data_o0, Data_o1, Data_o2, Data_o3}, cur);
      end
      if (Data_parity_err) begin
        perr_cnt++;
        chk("parity_err_hold", {Data_o0, Data_o1, Data_o2, Data_o3}, cur);
      end
    end
  end

  task automatic send_frame(input logic [W-1:0] a, b, c, d, input int first, input int last,
                            input bit gap, input bit badpar);
    logic [4*W:0] v;
    v = {a, b, c, d, (^{a, b, c, d}) ^ badpar};
    for (int i = first; i < last; i++) begin
      Data_in   = v[4*W-i];
      Data_sync = (i == 0);
      Data_en   = 1'b1;
      @(posedge clk); #1;
      Data_en   = 1'b0;
      Data_sync = 1'b0;
      if (i != FB - 1 && !Data_busy) busy_drop = 1'b1;
      if (gap && i != last - 1) begin
        @(posedge clk); #1;
        if (!Data_busy) busy_drop = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 0);
    chk("reset_busy", Data_busy, 0);
    chk("reset_pulses", {Data_frame_done, Data_sync_err, Data_parity_err}, 0);

    for (int i = 0; i < 5; i++) begin
      Data_in = 1'b1; Data_en = 1'b1; Data_sync = 1'b0;
      @(posedge clk); #1;
    end
    Data_en = 1'b0;
    chk("hunt_discard_busy", Data_busy, 0);

    exp_q.push_back(32'hA53CFF01);
    busy_drop = 1'b0;
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, FB, 1'b0, 1'b0);
    chk("basic_done", Data_frame_done, 1);
    chk("basic_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 32'hA53CFF01);
    chk("basic_busy", busy_drop, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", Data_frame_done, 0);
    chk("idle_busy", Data_busy, 0);

    exp_q.push_back(32'hA53CFF01);
    busy_drop = 1'b0;
    t0 = cyc;
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, FB, 1'b1, 1'b0);
    chk("gap_done", Data_frame_done, 1);
    chk("gap_latency", cyc - t0, 2 * FB - 1);
    chk("gap_busy", busy_drop, 0);

    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h9ABCDEF0);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 0, FB, 1'b0, 1'b0);
    send_frame(8'h9A, 8'hBC, 8'hDE, 8'hF0, 0, FB, 1'b0, 1'b0);
    chk("b2b_done", Data_frame_done, 1);
    chk("b2b_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 32'h9ABCDEF0);

    send_frame(8'h5A, 8'hC3, 8'h69, 8'h96, 0, 12, 1'b0, 1'b0);
    chk("mid_busy", Data_busy, 1);
    exp_q.push_back(32'h11223344);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0, FB, 1'b0, 1'b0);
    chk("resync_done", Data_frame_done, 1);
    chk("resync_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 32'h11223344);

    send_frame(8'h77, 8'h66, 8'h55, 8'h44, 0, 20, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rstmid_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 0);
    chk("rstmid_busy", Data_busy, 0);
    chk("rstmid_pulses", {Data_frame_done, Data_sync_err, Data_parity_err}, 0);
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, FB - 1, 1'b0, 1'b0);
    chk("pre_done_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 0);
    chk("pre_done_busy", Data_busy, 1);
    exp_q.push_back(32'hDEADBEEF);
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, FB - 1, FB, 1'b0, 1'b0);
    chk("deadbeef_done", Data_frame_done, 1);
    chk("deadbeef_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 32'hDEADBEEF);

`ifdef TDM_DEMUX_PARITY_EN
    exp_q.push_back(32'hA53CFF01);
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, FB, 1'b0, 1'b0);
    chk("par_good_done", Data_frame_done, 1);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 0, FB, 1'b0, 1'b1);
    chk("par_bad_pulse", Data_parity_err, 1);
    chk("par_bad_no_done", Data_frame_done, 0);
    chk("par_bad_out", {Data_o0, Data_o1, Data_o2, Data_o3}, 32'hA53CFF01);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", done_cnt, DONE_EXP);
    chk("sync_err_count", serr_cnt, 1);
    chk("parity_err_count", perr_cnt, PERR_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
